// File: rtl/sram_arbiter.sv
// sram_arbiter: shares the single image SRAM between two read requesters.
//   Port 0: Gaussian/row-buffer fetch. Port 1: keypoint filter/match fetch.
// Grants are round-robin with burst lock, gated by the top-level state.
// The arbiter drives SRAM chip-select/address and tags returned data with its owner.
// Optional build macro SRAM_ARB_STRICT_PRIO_EN switches to fixed priority, where
// port 0 always wins contention. The default build is round-robin.
module sram_arbiter #(
   parameter int ADDR_W    = 9,
   parameter int IMG_ROWS  = 480,
   parameter int BURST_MAX = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        state,
   input  logic              req0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic              last0,
   input  logic              last1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              sram_cs,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              rd_valid,
   output logic              rd_id,
   output logic              addr_err
);

   typedef enum logic [1:0] {S_IDLE, S_G0, S_G1} arb_state_t;

   localparam logic [ADDR_W:0] ROW_LIM  = (ADDR_W+1)'(IMG_ROWS);
   localparam logic [4:0]      BEAT_LIM = 5'(BURST_MAX);

   arb_state_t        fsm, fsm_nxt, pick;
   logic [3:0]        beat_cnt;
   logic [4:0]        cnt_inc;
   logic              elig0, elig1, cand0, cand1;
   logic              beat_id, req_g, elig_g, last_g, beat, in_range, burst_end;
   logic [ADDR_W-1:0] beat_addr;
   logic              prefer1;
   logic              cs_id;

   // Eligibility by top-level state and the view of the currently granted port.
   always_comb begin
      elig0     = (state >= 3'd1) && (state <= 3'd4);
      elig1     = (state >= 3'd2) && (state <= 3'd4);
      cand0     = req0 && elig0;
      cand1     = req1 && elig1;
      beat_id   = (fsm == S_G1);
      req_g     = beat_id ? req1  : req0;
      elig_g    = beat_id ? elig1 : elig0;
      last_g    = beat_id ? last1 : last0;
      beat_addr = beat_id ? addr1 : addr0;
      beat      = (fsm != S_IDLE) && req_g;
      in_range  = ({1'b0, beat_addr} < ROW_LIM);
      cnt_inc   = {1'b0, beat_cnt} + 5'd1;
      // A beat taken while becoming ineligible still counts; it only ends the burst.
      burst_end = (fsm != S_IDLE) &&
                  (!req_g || !elig_g || last_g || (cnt_inc == BEAT_LIM));
   end

`ifdef SRAM_ARB_STRICT_PRIO_EN
   // Fixed priority: port 0 wins every contention.
   assign prefer1 = 1'b0;
`else
   logic last_served;

   // Round-robin: prefer the port not served last (the one just ending its burst).
   assign prefer1 = (fsm == S_IDLE) ? !last_served : !beat_id;

   // Remember which port owned the most recently ended burst.
   always_ff @(posedge clk) begin
      if (rst)
         last_served <= 1'b1;
      else if (burst_end)
         last_served <= beat_id;
   end
`endif

   // Next-state selection; the same rule serves idle grants and burst handoff.
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      fsm_nxt = fsm;
      pick    = S_IDLE;
      if (cand0 && cand1)
         pick = prefer1 ? S_G1 : S_G0;
      else if (cand0)
         pick = S_G0;
      else if (cand1)
         pick = S_G1;
      case (fsm)
         S_IDLE:     fsm_nxt = pick;
         S_G0, S_G1: if (burst_end) fsm_nxt = pick;
         default:    fsm_nxt = S_IDLE;
      endcase
   end

   // FSM state register and beat counter (cleared on every new grant).
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         fsm      <= S_IDLE;
         beat_cnt <= 4'd0;
      end else begin
         fsm <= fsm_nxt;
         if (fsm == S_IDLE || burst_end)
            beat_cnt <= 4'd0;
         else if (beat)
            beat_cnt <= cnt_inc[3:0];
      end
   end

   assign gnt0 = (fsm == S_G0);
   assign gnt1 = (fsm == S_G1);

   // SRAM access issue, one-cycle read return tagging and sticky range error.
   always_ff @(posedge clk) begin
      if (rst) begin
         sram_cs   <= 1'b0;
         sram_addr <= '0;
         cs_id     <= 1'b0;
         rd_valid  <= 1'b0;
         rd_id     <= 1'b0;
         addr_err  <= 1'b0;
      end else begin
         sram_cs <= beat && in_range;
         if (beat && in_range) begin
            sram_addr <= beat_addr;
            cs_id     <= beat_id;
         end
         rd_valid <= sram_cs;
         rd_id    <= cs_id;
         if (state == 3'd0)
            addr_err <= 1'b0;
         else if (beat && !in_range)
            addr_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed self-checking bench for sram_arbiter.
// Inputs change 1 time unit after a rising edge; outputs are read at that point too,
// so each read shows the response to the inputs sampled at that edge.
module tb_sram_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] state;
   logic       req0, req1, last0, last1;
   logic [8:0] addr0, addr1;
   logic       gnt0, gnt1, sram_cs, rd_valid, rd_id, addr_err;
   logic [8:0] sram_addr;

   int checks = 0;
   int errors = 0;

   sram_arbiter #(.ADDR_W(9), .IMG_ROWS(480), .BURST_MAX(8)) dut (
      .clk(clk), .rst(rst), .state(state),
      .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
      .last0(last0), .last1(last1), .gnt0(gnt0), .gnt1(gnt1),
      .sram_cs(sram_cs), .sram_addr(sram_addr),
      .rd_valid(rd_valid), .rd_id(rd_id), .addr_err(addr_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; state = 3'd0;
      req0 = 1'b0; req1 = 1'b0; last0 = 1'b0; last1 = 1'b0;
      addr0 = '0; addr1 = '0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; state = 3'd1; req0 = 1'b1; req1 = 1'b1;
      last0 = 1'b0; last1 = 1'b0; addr0 = 9'd7; addr1 = 9'd9;
      tick(); tick();
      checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL reset_gnt0 got %0b exp 0", gnt0); end
      checks++; if (gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt1 got %0b exp 0", gnt1); end
      checks++; if (sram_cs !== 1'b0) begin errors++; $display("FAIL reset_cs got %0b exp 0", sram_cs); end
      checks++; if (sram_addr !== 9'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", sram_addr); end
      checks++; if (rd_valid !== 1'b0 || rd_id !== 1'b0) begin errors++; $display("FAIL reset_rd got %0b/%0b exp 0/0", rd_valid, rd_id); end
      checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", addr_err); end
      rst = 1'b0;
      tick();
      // state 1: only port 0 is eligible
      checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL reset_first_gnt got %0b%0b exp 10", gnt0, gnt1); end
   endtask

   task automatic test_single_burst();
      do_reset();
      state = 3'd1; req0 = 1'b1; addr0 = 9'd0;
      tick();
      checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL single_gnt got %0b exp 1", gnt0); end
      for (int i = 0; i < 4; i++) begin
         addr0 = 9'(i); last0 = (i == 3);
         tick();
         checks++; if (sram_cs !== 1'b1 || sram_addr !== 9'(i)) begin errors++; $display("FAIL single_beat%0d got cs=%0b addr=%0d exp cs=1 addr=%0d", i, sram_cs, sram_addr, i); end
         checks++; if (rd_valid !== (i >= 1) || rd_id !== 1'b0) begin errors++; $display("FAIL single_rd%0d got %0b/%0b exp %0b/0", i, rd_valid, rd_id, (i >= 1)); end
      end
      // last0 ended the burst; port 1 is ineligible so port 0 is regranted back-to-back
      checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL single_regrant got %0b%0b exp 10", gnt0, gnt1); end
      req0 = 1'b0; last0 = 1'b0;
      tick();
      checks++; if (gnt0 !== 1'b0 || sram_cs !== 1'b0) begin errors++; $display("FAIL single_release got gnt0=%0b cs=%0b exp 0/0", gnt0, sram_cs); end
      checks++; if (rd_valid !== 1'b1 || rd_id !== 1'b0) begin errors++; $display("FAIL single_rd_last got %0b/%0b exp 1/0", rd_valid, rd_id); end
      tick();
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL single_rd_done got %0b exp 0", rd_valid); end
   endtask

   task automatic test_contention();
      logic owner;
      int   cnt;
      logic [8:0] exp_addr;
      do_reset();
      state = 3'd4; req0 = 1'b1; req1 = 1'b1; addr0 = 9'd10; addr1 = 9'd20;
      tick();
      checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL cont_first got %0b%0b exp 10", gnt0, gnt1); end
      owner = 1'b0; cnt = 0;
      for (int i = 0; i < 32; i++) begin
         exp_addr = owner ? 9'd20 : 9'd10;
         tick();
         cnt++;
         if (cnt == 8) begin
            cnt = 0;
`ifndef SRAM_ARB_STRICT_PRIO_EN
            owner = ~owner;
`endif
         end
         checks++; if (gnt0 !== !owner || gnt1 !== owner) begin errors++; $display("FAIL cont_gnt%0d got %0b%0b exp %0b%0b", i, gnt0, gnt1, !owner, owner); end
         checks++; if (sram_cs !== 1'b1 || sram_addr !== exp_addr) begin errors++; $display("FAIL cont_beat%0d got cs=%0b addr=%0d exp cs=1 addr=%0d", i, sram_cs, sram_addr, exp_addr); end
      end
   endtask

   task automatic test_gating();
      do_reset();
      state = 3'd1; req1 = 1'b1; addr1 = 9'd33;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (gnt1 !== 1'b0) begin errors++; $display("FAIL gate_gnt1_%0d got %0b exp 0", i, gnt1); end
      end
      req0 = 1'b1; addr0 = 9'd5;
      tick();
      checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL gate_gnt0 got %0b%0b exp 10", gnt0, gnt1); end
      addr0 = 9'd6;
      tick();
      checks++; if (sram_cs !== 1'b1 || sram_addr !== 9'd6) begin errors++; $display("FAIL gate_beat6 got cs=%0b addr=%0d exp 1/6", sram_cs, sram_addr); end
      state = 3'd5; addr0 = 9'd7;
      tick();
      checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL gate_drop got %0b exp 0", gnt0); end
      checks++; if (sram_cs !== 1'b1 || sram_addr !== 9'd7) begin errors++; $display("FAIL gate_beat7 got cs=%0b addr=%0d exp 1/7", sram_cs, sram_addr); end
      tick();
      checks++; if (rd_valid !== 1'b1 || rd_id !== 1'b0) begin errors++; $display("FAIL gate_rd got %0b/%0b exp 1/0", rd_valid, rd_id); end
      checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || sram_cs !== 1'b0) begin errors++; $display("FAIL gate_idle got %0b%0b cs=%0b exp 00 cs=0", gnt0, gnt1, sram_cs); end
   endtask

   task automatic test_range();
      do_reset();
      state = 3'd1; req0 = 1'b1; addr0 = 9'd2;
      tick();
      addr0 = 9'd480;
      tick();
      checks++; if (sram_cs !== 1'b0 || sram_addr !== 9'd0) begin errors++; $display("FAIL range_cs got cs=%0b addr=%0d exp 0/0", sram_cs, sram_addr); end
      checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL range_err got %0b exp 1", addr_err); end
      checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL range_gnt got %0b exp 1", gnt0); end
      addr0 = 9'd479;
      tick();
      checks++; if (sram_cs !== 1'b1 || sram_addr !== 9'd479) begin errors++; $display("FAIL range_479 got cs=%0b addr=%0d exp 1/479", sram_cs, sram_addr); end
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL range_no_rd got %0b exp 0", rd_valid); end
      req0 = 1'b0;
      tick();
      state = 3'd2;
      tick();
      checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL range_sticky got %0b exp 1", addr_err); end
      state = 3'd0;
      tick();
      checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL range_clear got %0b exp 0", addr_err); end
   endtask

   task automatic test_early_release();
      do_reset();
      state = 3'd2; req1 = 1'b1; addr1 = 9'd40; addr0 = 9'd50;
      tick();
      checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errors++; $display("FAIL early_gnt1 got %0b%0b exp 01", gnt0, gnt1); end
      req0 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errors++; $display("FAIL early_hold%0d got %0b%0b exp 01", i, gnt0, gnt1); end
      end
      req1 = 1'b0;
      tick();
      checks++; if (gnt1 !== 1'b0 || gnt0 !== 1'b1) begin errors++; $display("FAIL early_handoff got %0b%0b exp 10", gnt0, gnt1); end
      checks++; if (sram_cs !== 1'b0) begin errors++; $display("FAIL early_no_access got %0b exp 0", sram_cs); end
      checks++; if (rd_valid !== 1'b1 || rd_id !== 1'b1) begin errors++; $display("FAIL early_rd1 got %0b/%0b exp 1/1", rd_valid, rd_id); end
      tick();
      checks++; if (sram_cs !== 1'b1 || sram_addr !== 9'd50) begin errors++; $display("FAIL early_beat0 got cs=%0b addr=%0d exp 1/50", sram_cs, sram_addr); end
      rst = 1'b1;
      tick();
      checks++; if (gnt0 !== 1'b0 || sram_cs !== 1'b0 || rd_valid !== 1'b0 || sram_addr !== 9'd0) begin errors++; $display("FAIL midrst got gnt0=%0b cs=%0b rv=%0b addr=%0d exp 0/0/0/0", gnt0, sram_cs, rd_valid, sram_addr); end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_contention();
      test_gating();
      test_range();
      test_early_release();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

- Shares the single 9-bit-addressed image SRAM between two read requesters:
  - Port 0: Gaussian/row-buffer fetch.
  - Port 1: keypoint filter/match fetch.
- Round-robin grants with burst lock and top-level-state gating.
- Drives SRAM chip-select/address and tags returned data with its owner.
- Sits between the top-level FSM, the requesters and the image SRAM; replaces per-requester address counters driving the SRAM directly.

## Interface

Parameters:
- ADDR_W, 9, SRAM address width.
- IMG_ROWS, 480, number of valid addresses (0..IMG_ROWS-1).
- BURST_MAX, 8, maximum beats per grant, 1..16.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- state  input  3  top-level state: 0 IDLE, 1 GAUSSIAN, 2 DETECT_KP, 3 FILTER_KP, 4 MATCH, 5 END.
- req0 / req1  input  1  requester wants a read beat this cycle.
- addr0 / addr1  input  ADDR_W  address of the offered beat.
- last0 / last1  input  1  offered beat is the final beat of the burst.
- gnt0 / gnt1  output  1  registered grant; a beat transfers when gntX && reqX.
- sram_cs  output  1  registered SRAM read enable.
- sram_addr  output  ADDR_W  registered SRAM address.
- rd_valid  output  1  SRAM read data valid this cycle.
- rd_id  output  1  owner of the data: 0 = port 0, 1 = port 1.
- addr_err  output  1  sticky; an out-of-range address was offered on a granted beat.

## Operation

- FSM states:
  - S_IDLE: no grant.
  - S_G0: gnt0=1.
  - S_G1: gnt1=1.
- Eligibility:
  - req0 is eligible in state 1–4; req1 is eligible in state 2–4.
  - In state 0 or 5 nothing is eligible.
- Grant selection from S_IDLE:
  - One eligible requester: grant it.
  - Both eligible: grant the one not served last. `last_served` is 1 bit, reset to 1 so port 0 wins first.
- Beat counter: 4-bit, cleared on every new grant, incremented on each beat.
- Burst ends on any of:
  - a beat with lastX=1;
  - a beat that brings the count to BURST_MAX;
  - the granted reqX low for one cycle;
  - the requester becoming ineligible.
- At burst end, `last_served` is updated and the next state is chosen with the S_IDLE selection rule. This gives a direct handoff S_G0→S_G1 (and S_G1→S_G0) with no idle cycle. A requester may be regranted back-to-back only if the other one is not eligible.
- Address check on every beat:
  - addrX >= IMG_ROWS: beat is consumed, but sram_cs stays 0 (no access) and addr_err sets.
  - addr_err clears only on rst or when state==0.
- State 0 or 5 forces S_IDLE and drops both grants next cycle. Any in-flight read still returns rd_valid.
- At most one of gnt0/gnt1 is ever high.

## Timing

- Reset values: gnt0=gnt1=0, sram_cs=0, sram_addr=0, rd_valid=0, rd_id=0, addr_err=0, FSM=S_IDLE, beat count=0, last_served=1.
- Request to grant: a request at cycle N while in S_IDLE gives a grant at N+1.
- Beat to SRAM: a beat at cycle N drives sram_cs=1 and sram_addr=addrX at N+1 (sram_addr holds its value when sram_cs=0).
- Read return: SRAM has one-cycle registered read, so rd_valid=1 with rd_id=X at N+2. Throughput is one beat per cycle.
- Burst end at a beat in cycle N:
  - the old grant drops at N+1;
  - the new grant, if any, rises at N+1.
- Burst end by reqX low at cycle N: the grant drops at N+1, and no access is generated for cycle N.
- Simultaneous events:
  - lastX and count reaching BURST_MAX on the same beat give a single burst end.
  - An ineligibility change and a beat in the same cycle: the beat still counts (it was granted).
- rst mid-burst: all outputs return to reset values next cycle. rd_valid for a beat already issued is lost, and requesters must reissue.

## Configuration

- SRAM_ARB_STRICT_PRIO_EN:
  - Defined: fixed priority. Port 0 always wins when both are eligible, and `last_served` is ignored. Burst lock and BURST_MAX still apply, so port 1 is served only when port 0 is idle or ineligible.
  - Undefined (default): round-robin as described above.

## Test plan

- Reset: rst=1 for 2 cycles with req0=req1=1 → all outputs 0, no grant until the cycle after rst falls and state is nonzero.
- Single burst, state=1, req0 with addr0=0..3 and last0 on addr 3:
  - gnt0 at N+1;
  - sram_addr 0,1,2,3 on consecutive cycles;
  - rd_valid with rd_id=0 four times;
  - gnt0 low after the fourth beat.
- Contention, state=4, both requesting continuous streams without last:
  - bursts alternate 8 beats port 0, then 8 beats port 1, with no idle cycle between them;
  - with SRAM_ARB_STRICT_PRIO_EN defined, port 1 is never granted.
- Gating: state=1 with req1=1 → gnt1 never asserts. Switch to state=5 mid-burst → grant drops next cycle and the last issued beat's rd_valid still appears.
- Range: a granted beat with addr0=480 → sram_cs stays 0 and addr_err=1, which persists until state=0.
- Early release: req1 drops after 3 beats while req0 is pending → gnt1 falls and gnt0 rises in the same cycle.
